// File: rtl/zap_copro_dispatch_pkg.sv
// Shared types, encodings and helpers for the ZAP coprocessor dispatcher.
package zap_copro_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TRAP = 2'd2
  } copro_state_t;

  typedef enum logic [2:0] {
    CP_OP_NONE = 3'd0,
    CP_OP_MRC  = 3'd1,
    CP_OP_MCR  = 3'd2,
    CP_OP_LDC  = 3'd3,
    CP_OP_STC  = 3'd4,
    CP_OP_CDP  = 3'd5
  } copro_op_t;

  // Word injected while the pipeline drains for a dispatch.
  localparam logic [31:0] NOP_WORD  = 32'hF0000000;

  localparam logic [4:0]  MODE_USR  = 5'b10000;
  localparam logic [4:0]  MODE_SVC  = 5'b10011;

  // Instruction bits [11:8] carry the coprocessor number.
  localparam int          CP_NUM_W  = 4;

  // Classify an ARM word as one of the coprocessor operations.
  function automatic copro_op_t decode_copro(input logic [31:0] insn);
    copro_op_t op;
    op = CP_OP_NONE;
    if (insn[27:25] == 3'b110) begin
      op = insn[20] ? CP_OP_LDC : CP_OP_STC;
    end else if (insn[27:24] == 4'b1110) begin
      if (insn[4]) op = insn[20] ? CP_OP_MRC : CP_OP_MCR;
      else         op = CP_OP_CDP;
    end
    return op;
  endfunction

  // Effective presence mask: a CP number must both be enabled and map onto a built channel.
  function automatic logic [15:0] cp_present_mask(input int num_cp, input logic [15:0] en);
    logic [15:0] m;
    for (int n = 0; n < 16; n++) begin
      m[n] = en[n] && (n < num_cp);
    end
    return m;
  endfunction

endpackage

// File: rtl/zap_copro_watchdog.sv
// Cycle counter bounding how long a coprocessor may keep the dispatcher busy.
module zap_copro_watchdog
  import zap_copro_dispatch_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over enable, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (i_clear)       count_d = '0;
    else if (i_enable) count_d = count_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) count_q <= '0;
    else         count_q <= count_d;
  end

  assign o_expired = (count_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/zap_copro_dispatch.sv
// Predecode-stage coprocessor dispatcher: drains the pipeline, hands the word to
// one coprocessor channel and turns absent/rejected/timed-out accesses into UND slots.
module zap_copro_dispatch
  import zap_copro_dispatch_pkg::*;
#(
  parameter int          NUM_CP    = 16,
  parameter logic [15:0] CP_EN     = 16'hFFFF,
  parameter int          TIMEOUT   = 255,
  parameter bit          ALLOW_USR = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       i_instruction,
  input  logic              i_valid,
  input  logic              i_cpsr_ff_t,
  input  logic [4:0]        i_cpsr_ff_mode,
  input  logic              i_irq,
  input  logic              i_fiq,
  input  logic              i_code_stall,
  input  logic              i_clear_from_writeback,
  input  logic              i_data_stall,
  input  logic              i_clear_from_alu,
  input  logic              i_stall_from_shifter,
  input  logic              i_stall_from_issue,
  input  logic              i_pipeline_dav,
  input  logic [NUM_CP-1:0] i_copro_done,
  input  logic [NUM_CP-1:0] i_copro_err,
  output logic              o_irq,
  output logic              o_fiq,
  output logic [31:0]       o_instruction,
  output logic              o_valid,
  output logic              o_und,
  output logic              o_stall_from_decode,
  output logic [NUM_CP-1:0] o_copro_dav_ff,
  output logic [31:0]       o_copro_word_ff
);

  localparam logic [15:0] PRESENT = cp_present_mask(NUM_CP, CP_EN);

  copro_state_t        state_q,  state_d;
  logic [NUM_CP-1:0]   cp_dav_q, cp_dav_d;
  logic [31:0]         cp_word_q, cp_word_d;
  logic [CP_NUM_W-1:0] ch_q,     ch_d;

  logic                wd_clear;
  logic                wd_enable;
  logic                wd_expired;

  logic [CP_NUM_W-1:0] cp_num;
  logic                cp_insn;
  logic                cp_reject;
  logic                done_sel;
  logic                err_sel;

  assign cp_num    = i_instruction[11:8];
  assign cp_insn   = i_valid && !i_cpsr_ff_t && (decode_copro(i_instruction) != CP_OP_NONE);
  assign cp_reject = !PRESENT[cp_num] || (!ALLOW_USR && (i_cpsr_ff_mode == MODE_USR));

  // Pick the completion/reject strobes of the channel currently being served.
  always_comb begin
    done_sel = 1'b0;
    err_sel  = 1'b0;
    for (int i = 0; i < NUM_CP; i++) begin
      if (ch_q == CP_NUM_W'(i)) begin
        done_sel = i_copro_done[i];
        err_sel  = i_copro_err[i];
      end
    end
  end

  // Next-state logic, honouring the stall/clear priority chain before advancing the FSM.
  always_comb begin
    state_d   = state_q;
    cp_dav_d  = cp_dav_q;
    cp_word_d = cp_word_q;
    ch_d      = ch_q;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    if (i_code_stall) begin
      // hold everything
    end else if (i_clear_from_writeback) begin
      state_d  = ST_IDLE;
      cp_dav_d = '0;
      wd_clear = 1'b1;
    end else if (i_data_stall) begin
      // hold everything
    end else if (i_clear_from_alu) begin
      state_d  = ST_IDLE;
      cp_dav_d = '0;
      wd_clear = 1'b1;
    end else if (i_stall_from_shifter || i_stall_from_issue) begin
      // hold everything
    end else begin
      case (state_q)
        ST_IDLE: begin
          wd_clear = 1'b1;
          if (cp_insn && !cp_reject && !i_pipeline_dav) begin
            cp_word_d = i_instruction;
            ch_d      = cp_num;
            for (int i = 0; i < NUM_CP; i++) begin
              cp_dav_d[i] = (cp_num == CP_NUM_W'(i));
            end
            state_d   = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done_sel) begin
            cp_dav_d = '0;
            state_d  = ST_IDLE;
          end else if (err_sel || wd_expired) begin
            cp_dav_d = '0;
            state_d  = ST_TRAP;
          end else begin
            wd_enable = 1'b1;
          end
        end
        ST_TRAP: begin
          wd_clear = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          cp_dav_d = '0;
          wd_clear = 1'b1;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  // FSM and request/word registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      cp_dav_q  <= '0;
      cp_word_q <= '0;
      ch_q      <= '0;
    end else begin
      state_q   <= state_d;
      cp_dav_q  <= cp_dav_d;
      cp_word_q <= cp_word_d;
      ch_q      <= ch_d;
    end
  end

  // Output slot towards decode as a function of the current state and incoming word.
  always_comb begin
    o_instruction       = i_instruction;
    o_valid             = i_valid;
    o_und               = 1'b0;
    o_stall_from_decode = 1'b0;
    o_irq               = i_irq;
    o_fiq               = i_fiq;
    case (state_q)
      ST_IDLE: begin
        if (cp_insn) begin
          if (cp_reject) begin
            o_und = 1'b1;
          end else begin
            o_valid             = 1'b0;
            o_instruction       = NOP_WORD;
            o_irq               = 1'b0;
            o_fiq               = 1'b0;
            o_stall_from_decode = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        o_valid             = 1'b0;
        o_instruction       = '0;
        o_irq               = 1'b0;
        o_fiq               = 1'b0;
        // Completion releases the upstream stall in the same cycle.
        o_stall_from_decode = !done_sel;
      end
      ST_TRAP: begin
        o_instruction = cp_word_q;
        o_valid       = 1'b1;
        o_und         = 1'b1;
        o_irq         = 1'b0;
        o_fiq         = 1'b0;
      end
      default: begin
        o_valid = 1'b0;
      end
    endcase
  end

  assign o_copro_dav_ff  = cp_dav_q;
  assign o_copro_word_ff = cp_word_q;

  zap_copro_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (wd_clear),
    .i_enable  (wd_enable),
    .o_expired (wd_expired)
  );

endmodule

// File: tb/tb_zap_copro_dispatch.sv
// Directed bench for zap_copro_dispatch (CP3 absent, TIMEOUT=4).
module tb_zap_copro_dispatch;

  localparam logic [31:0] ADD_W  = 32'hE0810002;
  localparam logic [31:0] MCR15  = 32'hEE010F10;
  localparam logic [31:0] MRC3   = 32'hEE110310;
  localparam logic [31:0] CDP1   = 32'hEE000100;
  localparam logic [31:0] MRC2   = 32'hEE110210;
  localparam logic [31:0] MCR7   = 32'hEE010710;
  localparam logic [31:0] NOP_W  = 32'hF0000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        valid, thumb, irq, fiq;
  logic [4:0]  mode;
  logic        code_stall, clr_wb, data_stall, clr_alu, sh_stall, is_stall, pdav;
  logic [15:0] done, err;
  logic        o_irq, o_fiq, o_valid, o_und, o_stall;
  logic [31:0] o_instr, o_word;
  logic [15:0] o_dav;

  int total = 0;
  int bad   = 0;

  zap_copro_dispatch #(
    .NUM_CP    (16),
    .CP_EN     (16'hFFF7),
    .TIMEOUT   (4),
    .ALLOW_USR (1'b0)
  ) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_instruction          (instr),
    .i_valid                (valid),
    .i_cpsr_ff_t            (thumb),
    .i_cpsr_ff_mode         (mode),
    .i_irq                  (irq),
    .i_fiq                  (fiq),
    .i_code_stall           (code_stall),
    .i_clear_from_writeback (clr_wb),
    .i_data_stall           (data_stall),
    .i_clear_from_alu       (clr_alu),
    .i_stall_from_shifter   (sh_stall),
    .i_stall_from_issue     (is_stall),
    .i_pipeline_dav         (pdav),
    .i_copro_done           (done),
    .i_copro_err            (err),
    .o_irq                  (o_irq),
    .o_fiq                  (o_fiq),
    .o_instruction          (o_instr),
    .o_valid                (o_valid),
    .o_und                  (o_und),
    .o_stall_from_decode    (o_stall),
    .o_copro_dav_ff         (o_dav),
    .o_copro_word_ff        (o_word)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Combinational slot check: instruction, valid, und, stall, irq.
  task automatic chk_slot(input string tag, input logic [31:0] ei, input logic ev,
                          input logic eu, input logic es, input logic eirq);
    #1;
    chk({tag, ".instr"}, o_instr, ei);
    chk({tag, ".valid"}, {31'd0, o_valid}, {31'd0, ev});
    chk({tag, ".und"},   {31'd0, o_und},   {31'd0, eu});
    chk({tag, ".stall"}, {31'd0, o_stall}, {31'd0, es});
    chk({tag, ".irq"},   {31'd0, o_irq},   {31'd0, eirq});
  endtask

  initial begin
    rst = 1'b1; instr = ADD_W; valid = 1'b1; thumb = 1'b0; irq = 1'b1; fiq = 1'b0;
    mode = 5'b10011; code_stall = 1'b0; clr_wb = 1'b0; data_stall = 1'b0;
    clr_alu = 1'b0; sh_stall = 1'b0; is_stall = 1'b0; pdav = 1'b0; done = '0; err = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state and transparent ADD in SVC
    chk("rst.dav",  {16'd0, o_dav}, 32'd0);
    chk("rst.word", o_word, 32'd0);
    chk_slot("add", ADD_W, 1'b1, 1'b0, 1'b0, 1'b1);

    // Thumb makes a coprocessor pattern transparent
    thumb = 1'b1; instr = MCR15;
    chk_slot("thumb", MCR15, 1'b1, 1'b0, 1'b0, 1'b1);
    thumb = 1'b0;

    // MCR p15 while downstream busy for three cycles
    pdav = 1'b1;
    chk_slot("mcr.w1", NOP_W, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_slot("mcr.w2", NOP_W, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_slot("mcr.w3", NOP_W, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    pdav = 1'b0;
    chk("mcr.c4.dav", {16'd0, o_dav}, 32'd0);
    tick();
    chk("mcr.c5.dav",  {16'd0, o_dav}, 32'h0000_8000);
    chk("mcr.c5.word", o_word, MCR15);
    chk_slot("mcr.busy", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    done[15] = 1'b1;
    chk_slot("mcr.done", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    done = '0; instr = ADD_W;
    chk("mcr.idle.dav", {16'd0, o_dav}, 32'd0);
    chk_slot("mcr.idle", ADD_W, 1'b1, 1'b0, 1'b0, 1'b1);

    // MRC p3 with CP3 absent
    instr = MRC3;
    chk_slot("absent", MRC3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("absent.dav", {16'd0, o_dav}, 32'd0);

    // USR mode trap on present CP15
    mode = 5'b10000; instr = MCR15;
    chk_slot("usr", MCR15, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("usr.dav", {16'd0, o_dav}, 32'd0);
    mode = 5'b10011;

    // CDP p1 with no completion: timeout after five BUSY cycles
    instr = CDP1;
    tick();
    instr = ADD_W;
    chk("cdp.dav", {16'd0, o_dav}, 32'h0000_0002);
    for (int b = 0; b < 5; b++) begin
      chk_slot("cdp.busy", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("cdp.trap.dav", {16'd0, o_dav}, 32'd0);
    chk_slot("cdp.trap", CDP1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_slot("cdp.idle", ADD_W, 1'b1, 1'b0, 1'b0, 1'b1);

    // MRC p2: foreign done ignored, own err traps
    instr = MRC2;
    tick();
    instr = ADD_W;
    chk("p2.dav", {16'd0, o_dav}, 32'h0000_0004);
    done[5] = 1'b1;
    chk_slot("p2.done5", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    done = '0;
    chk("p2.still.dav", {16'd0, o_dav}, 32'h0000_0004);
    err[2] = 1'b1;
    chk_slot("p2.err", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    err = '0;
    chk("p2.trap.dav", {16'd0, o_dav}, 32'd0);
    chk_slot("p2.trap", MRC2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // Clear from ALU mid-BUSY, first masked by a code stall
    instr = MCR7;
    tick();
    chk("clr.dav", {16'd0, o_dav}, 32'h0000_0080);
    clr_alu = 1'b1; code_stall = 1'b1;
    tick();
    chk("clr.held.dav", {16'd0, o_dav}, 32'h0000_0080);
    chk_slot("clr.held", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    code_stall = 1'b0;
    tick();
    clr_alu = 1'b0; instr = ADD_W;
    chk("clr.dav0", {16'd0, o_dav}, 32'd0);
    chk_slot("clr.idle", ADD_W, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
